// File: rtl/disp_digit_formatter.sv
// Converts two 14-bit amounts to BCD (sequential double-dabble) and formats them for the
// 8-digit seven-segment stage, with leading-zero blanking, overrange dashes and per-half blink.
module disp_digit_formatter #(
  parameter int BLINK_DIV   = 50000000,
  parameter int LZ_SUPPRESS = 1
) (
  input  logic        clk100MHZ,
  input  logic        rst_n,
  input  logic        load,
  input  logic [13:0] left_val,
  input  logic [13:0] right_val,
  input  logic        blink_l,
  input  logic        blink_r,
  output logic        busy,
  output logic        done,
  output logic [39:0] dig
);

  localparam int          CW         = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CW-1:0] BLINK_LAST = CW'(BLINK_DIV - 1);
  localparam logic [4:0]  CODE_BLANK = 5'd16;
  localparam logic [4:0]  CODE_DASH  = 5'd17;
  localparam logic [3:0]  LAST_ITER  = 4'd14;

  typedef enum logic {S_IDLE, S_CONV} state_t;

  state_t          state;
  logic [3:0]      iter;
  logic [13:0]     bin_l, bin_r;
  logic [15:0]     bcd_l, bcd_r;
  logic            ovr_l, ovr_r;
  logic [39:0]     held;
  logic [CW-1:0]   blink_cnt;
  logic            blink_on;

  // One double-dabble step: correct every nibble that would overflow past 9, then shift in.
  function automatic logic [15:0] dabble(input logic [15:0] bcd, input logic bit_in);
    logic [15:0] t;
    t = bcd;
    for (int i = 0; i < 4; i++) begin
      if (t[4*i +: 4] >= 4'd5) t[4*i +: 4] = t[4*i +: 4] + 4'd3;
    end
    return (t << 1) | {15'd0, bit_in};
  endfunction

  function automatic logic [19:0] fmt_half(input logic [15:0] bcd, input logic ovr);
    logic [19:0] res;
    logic        lead;
    logic [3:0]  nib;
    res  = '0;
    lead = (LZ_SUPPRESS != 0);
    for (int i = 3; i >= 0; i--) begin
      nib = bcd[4*i +: 4];
      if (ovr) begin
        res[5*i +: 5] = CODE_DASH;
      end else if (lead && (i != 0) && (nib == 4'd0)) begin
        res[5*i +: 5] = CODE_BLANK;
      end else begin
        res[5*i +: 5] = {1'b0, nib};
        lead          = 1'b0;
      end
    end
    return res;
  endfunction

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values and the shifters stay in lockstep regardless of statement order.
  // NOTE: the held digit register is reset (to blank) because it drives the display directly;
  // the shifter contents are reset too, keeping an aborted conversion from leaking anywhere.
  always_ff @(posedge clk100MHZ or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      iter  <= '0;
      bin_l <= '0;
      bin_r <= '0;
      bcd_l <= '0;
      bcd_r <= '0;
      ovr_l <= 1'b0;
      ovr_r <= 1'b0;
      held  <= {8{CODE_BLANK}};
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (load) begin
            bin_l <= left_val;
            bin_r <= right_val;
            bcd_l <= '0;
            bcd_r <= '0;
            ovr_l <= (left_val  > 14'd9999);
            ovr_r <= (right_val > 14'd9999);
            iter  <= '0;
            state <= S_CONV;
          end
        end
        S_CONV: begin
          if (iter == LAST_ITER) begin
            held  <= {fmt_half(bcd_l, ovr_l), fmt_half(bcd_r, ovr_r)};
            done  <= 1'b1;
            state <= S_IDLE;
          end else begin
            bcd_l <= dabble(bcd_l, bin_l[13]);
            bcd_r <= dabble(bcd_r, bin_r[13]);
            bin_l <= {bin_l[12:0], 1'b0};
            bin_r <= {bin_r[12:0], 1'b0};
            iter  <= iter + 4'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Free-running blink phase, deliberately independent of conversion activity.
  always_ff @(posedge clk100MHZ or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt <= '0;
      blink_on  <= ~blink_on;
    end else begin
      blink_cnt <= blink_cnt + CW'(1);
    end
  end

  assign busy = (state == S_CONV);
  assign dig  = {(blink_l && !blink_on) ? {4{CODE_BLANK}} : held[39:20],
                 (blink_r && !blink_on) ? {4{CODE_BLANK}} : held[19:0]};

endmodule

// File: doc/disp_digit_formatter.md
Name: disp_digit_formatter

Overview:
- Upstream feeder for the 8-digit seven-segment display stage. Produces its 40-bit `dig` bus.
- Takes two binary amounts from the shop controller, e.g. item price on the left half and paid/change on the right half.
- Converts each amount to four BCD digits with a sequential double-dabble, applies leading-zero blanking and overrange dashes, and gates each half with a free-running blink phase.
- Result is held stable until the next load.

Parameters:
- BLINK_DIV, 50000000, clk100MHZ cycles per blink half-period (0.5 s at 100 MHz).
- LZ_SUPPRESS, 1, 1 = blank leading zeros in each half; 0 = show them.

Ports:
- clk100MHZ  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous reset, active-low.
- load  input  1  start conversion of left_val/right_val; sampled only when busy=0.
- left_val  input  14  binary amount for digits 7..4.
- right_val  input  14  binary amount for digits 3..0.
- blink_l  input  1  level; blink left half.
- blink_r  input  1  level; blink right half.
- busy  output  1  conversion in progress.
- done  output  1  one-cycle pulse when new digits are committed.
- dig  output  40  digit codes; dig[5i+4:5i] = digit i; i=0 is rightmost (AN[0]).

Behaviour:
- Digit code set: 0..9 = decimal digit; 5'd16 = blank (all segments off); 5'd17 = dash (segment g only). No other codes are emitted.
- Reset (async, rst_n=0):
  - busy=0, done=0.
  - Held digits all blank, so dig = 5'd16 in every slot.
  - Blink counter=0, blink phase=ON.
  - Any conversion in flight is aborted with no done pulse.
- Idle: load=1 at edge E0 captures both values; busy=1 after E0.
- load while busy=1 is ignored; no queueing.
- Overrange is checked at capture: a value >9999 sets that half's overrange flag.
- Conversion:
  - Two parallel 14-iteration double-dabble shifters (14-bit binary, 16-bit BCD).
  - Each iteration: add 3 to any BCD nibble >=5, then shift left 1.
  - Iterations occur at edges E1..E14.
- Commit at edge E15:
  - Formatted digits are written to the held registers.
  - busy=0, done=1 for exactly one cycle (cleared at E16).
  - Total latency from load sample to new dig is 15 cycles.
  - A new load may be sampled at E16 (busy already 0 in the E15 cycle, so load high during cycle E15 is accepted at E16).
- Formatting per half, digits d3..d0 with d3 most significant:
  - Overrange: all four digits dash.
  - LZ_SUPPRESS=1: each leading zero from d3 down to d1 becomes blank until the first nonzero digit. d0 is always shown, so value 0 displays "   0".
  - LZ_SUPPRESS=0: all four digits shown as-is.
- Blink:
  - Counter runs 0..BLINK_DIV-1 continuously, independent of load and busy.
  - At wrap the counter returns to 0 and the phase toggles.
  - While phase=OFF and blink_x=1, that half outputs blank in all four digits. Otherwise it outputs the held digits.
  - Masking is a combinational function of registered state and the blink_x inputs: deasserting blink_x restores the digits in the same cycle.
- dig reflects only committed values; intermediate shifter contents never appear on dig.
- Reset asserted mid-conversion returns to the reset state immediately. After release, no done pulse occurs until a fresh load.

Test Plan:
- Reset: hold rst_n=0, then release -> busy=0, done=0, dig=40'h8421084210 (all slots 5'd16); the value stays put with no load.
- Load left_val=1234, right_val=56 at E0 -> busy=1 over E1..E14.
  - At E15 dig digits 7..4 = 1,2,3,4 and digits 3..0 = 16,16,5,6.
  - done high for exactly one cycle; busy=0.
- Load left_val=0, right_val=10000 -> left = 16,16,16,0; right = 17,17,17,17.
  - Repeat with LZ_SUPPRESS=0: left = 0,0,0,0.
- Load 9999/9999, then pulse load=1 with 7/7 at E5 -> second load ignored; E15 commits 9,9,9,9 on both halves.
  - A subsequent load of 7/7 at E16 commits 16,16,16,7 at E31.
- BLINK_DIV=4, committed 1234/5678, blink_l=1, blink_r=0:
  - left half alternates 1234 and all-blank every 4 cycles; right half steady.
  - Dropping blink_l restores 1234 in the same cycle.
- Assert rst_n=0 at E7 of a conversion -> dig all blank, busy=0, no done pulse.
  - After release, a new load of 42/0 commits 16,16,4,2 / 16,16,16,0 after 15 cycles.
